// File: rtl/trinity_pkg.sv
// -----------------------------------------------------------------------------
// trinity_pkg
// Shared definitions for the decode/backend boundary.
//   iq_bundle_t  : fully decoded instruction bundle carried by the issue queue.
//   IQ_BUNDLE_W  : packed width of one iq_bundle_t.
// -----------------------------------------------------------------------------
package trinity_pkg;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [63:0] imm;
        logic        src1_is_reg;
        logic        src2_is_reg;
        logic        need_to_wb;
        logic [2:0]  cx_type;
        logic        is_unsigned;
        logic [3:0]  alu_type;
        logic        is_word;
        logic        is_load;
        logic        is_imm;
        logic        is_store;
        logic [1:0]  ls_size;
        logic [2:0]  muldiv_type;
        logic        predict_taken;
        logic [31:0] predict_target;
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_bundle_t;

    localparam int IQ_BUNDLE_W = $bits(iq_bundle_t);

endpackage : trinity_pkg

// File: rtl/issue_queue_storage.sv
// -----------------------------------------------------------------------------
// iq_storage
// DEPTH x BUNDLE_W register array: one synchronous write port, one
// asynchronous read port. All entries clear on reset so the head reads zero
// straight out of reset.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data : write port (captured on posedge)
//   rd_addr/rd_data     : combinational read port
// -----------------------------------------------------------------------------
module iq_storage
    import trinity_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int BUNDLE_W = IQ_BUNDLE_W,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [BUNDLE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [BUNDLE_W-1:0] rd_data
);

    logic [BUNDLE_W-1:0] mem_r [DEPTH];

    // Entry array: cleared on reset, written on an accepted enqueue.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {BUNDLE_W{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : iq_storage

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
// In-order FIFO between decode and the execute/memory backend. The head entry
// is presented on deq_*; flush discards every buffered entry.
// Optional build macro: ISSUE_QUEUE_PERF_EN adds two 64-bit wrapping counters
// (cycles full, cycles head-valid-but-stalled), cleared only by reset.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   enq_valid/enq_ready/enq_bundle   : decode side handshake
//   deq_valid/deq_ready/deq_bundle   : backend side handshake
//   flush                            : backend redirect, empties the queue
//   count                            : current occupancy
//   perf_full_cycles/perf_stall_cycles : only with ISSUE_QUEUE_PERF_EN
// -----------------------------------------------------------------------------
module issue_queue
    import trinity_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int BUNDLE_W = IQ_BUNDLE_W,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int PTR_W    = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enq_valid,
    output logic                enq_ready,
    input  logic [BUNDLE_W-1:0] enq_bundle,
    output logic                deq_valid,
    input  logic                deq_ready,
    output logic [BUNDLE_W-1:0] deq_bundle,
    input  logic                flush,
    output logic [PTR_W-1:0]    count
`ifdef ISSUE_QUEUE_PERF_EN
    ,
    output logic [63:0]         perf_full_cycles,
    output logic [63:0]         perf_stall_cycles
`endif
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             enq_fire_s;
    logic             deq_fire_s;

    // Status derives from the pointers only, so no input reaches the outputs
    // combinationally. Full: same index, opposite wrap bit.
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                        (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]);
    assign enq_ready  = !full_s;
    assign deq_valid  = !empty_s;
    assign count      = wr_ptr_r - rd_ptr_r;
    assign enq_fire_s = enq_valid && !full_s && !flush;
    assign deq_fire_s = !empty_s && deq_ready && !flush;

    // Pointer update: reset and flush both rewind to zero, flush drops the
    // handshakes of its own cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    iq_storage #(
        .DEPTH    (DEPTH),
        .BUNDLE_W (BUNDLE_W),
        .IDX_W    (IDX_W)
    ) u_storage (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (enq_fire_s),
        .wr_addr  (wr_ptr_r[IDX_W-1:0]),
        .wr_data  (enq_bundle),
        .rd_addr  (rd_ptr_r[IDX_W-1:0]),
        .rd_data  (deq_bundle)
    );

`ifdef ISSUE_QUEUE_PERF_EN
    logic [63:0] perf_full_r;
    logic [63:0] perf_stall_r;

    // Performance counters: flush does not clear them, only reset does.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_full_r  <= 64'd0;
            perf_stall_r <= 64'd0;
        end else begin
            if (full_s) begin
                perf_full_r <= perf_full_r + 64'd1;
            end
            if (!empty_s && !deq_ready) begin
                perf_stall_r <= perf_stall_r + 64'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_r;
    assign perf_stall_cycles = perf_stall_r;
`endif

endmodule : issue_queue

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
// Self-checking bench for issue_queue (DEPTH = 4). A queue-of-bundles model
// tracks the expected contents; directed scenarios use hand-derived values.
// Define ISSUE_QUEUE_PERF_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_issue_queue;
    import trinity_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             enq_valid;
    logic             enq_ready;
    iq_bundle_t       enq_bundle;
    logic             deq_valid;
    logic             deq_ready;
    iq_bundle_t       deq_bundle;
    logic             flush;
    logic [PTR_W-1:0] count;
`ifdef ISSUE_QUEUE_PERF_EN
    logic [63:0]      perf_full_cycles;
    logic [63:0]      perf_stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    iq_bundle_t      model_q[$];
    longint unsigned m_full  = 0;
    longint unsigned m_stall = 0;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_bundle (enq_bundle),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_bundle (deq_bundle),
        .flush      (flush),
        .count      (count)
`ifdef ISSUE_QUEUE_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    function automatic iq_bundle_t rand_bundle(input logic [31:0] pc);
        iq_bundle_t b;
        b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        b.pc = pc;
        return b;
    endfunction

    // Advance one clock: update the reference model from the inputs present
    // before the edge, then step to just after the edge.
    task automatic tick();
        int  sz     = model_q.size();
        bit  do_deq = (sz > 0) && deq_ready;
        bit  do_enq = enq_valid && (sz < DEPTH);
        if (reset) begin
            model_q.delete();
            m_full  = 0;
            m_stall = 0;
        end else begin
            if (sz == DEPTH) m_full++;
            if (sz > 0 && !deq_ready) m_stall++;
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_deq) void'(model_q.pop_front());
                if (do_enq) model_q.push_back(enq_bundle);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid  = 1'b0;
        deq_ready  = 1'b0;
        flush      = 1'b0;
        enq_bundle = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (deq_bundle !== '0) begin failures++; $display("FAIL reset_deq_bundle got=%h exp=0", deq_bundle); end
`ifdef ISSUE_QUEUE_PERF_EN
        checks++; if (perf_full_cycles !== 64'd0 || perf_stall_cycles !== 64'd0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_full_cycles, perf_stall_cycles); end
`endif
    endtask

    task automatic test_in_order();
        int peak = 0;
        deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (int'(count) > peak) peak = int'(count);
            if (i >= 1 && i <= 3) begin
                checks++; if (deq_valid !== 1'b1 || deq_bundle.pc !== 32'h8000_0000 + 32'(4 * (i - 1))) begin
                    failures++; $display("FAIL in_order_head%0d got v=%b pc=%h exp pc=%h", i, deq_valid,
                                         deq_bundle.pc, 32'h8000_0000 + 32'(4 * (i - 1))); end
            end else begin
                checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL in_order_empty%0d got=%b exp=0", i, deq_valid); end
            end
            enq_valid  = (i < 3);
            enq_bundle = rand_bundle(32'h8000_0000 + 32'(4 * i));
            tick();
        end
        checks++; if (peak != 1) begin failures++; $display("FAIL in_order_peak got=%0d exp=1", peak); end
        idle_inputs();
    endtask

    task automatic test_fill_block();
        logic [31:0] base = 32'h8000_1000;
        int          j    = 0;
        deq_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enq_valid  = 1'b1;
            enq_bundle = rand_bundle(base + 32'(4 * k));
            tick();
        end
        checks++; if (enq_ready !== 1'b0 || count !== 3'd4) begin
            failures++; $display("FAIL fill_full got rdy=%b cnt=%0d exp rdy=0 cnt=4", enq_ready, count); end
        enq_bundle = rand_bundle(base + 32'd16);
        tick();
        tick();
        checks++; if (enq_ready !== 1'b0 || count !== 3'd4) begin
            failures++; $display("FAIL fill_hold got rdy=%b cnt=%0d exp rdy=0 cnt=4", enq_ready, count); end
        deq_ready = 1'b1;
        for (int c = 0; c < 20 && j < 5; c++) begin
            if (deq_valid) begin
                checks++; if (deq_bundle.pc !== base + 32'(4 * j)) begin
                    failures++; $display("FAIL fill_drain%0d got=%h exp=%h", j, deq_bundle.pc, base + 32'(4 * j)); end
                j++;
            end
            if (enq_valid && model_q.size() < DEPTH) begin
                tick();
                enq_valid = 1'b0;
            end else begin
                tick();
            end
        end
        checks++; if (j != 5) begin failures++; $display("FAIL fill_drain_timeout got=%0d exp=5", j); end
        idle_inputs();
    endtask

    task automatic test_simul_wrap();
        logic [31:0] base = 32'h8000_2000;
        int          next_in  = 0;
        int          next_out = 0;
        deq_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enq_valid  = 1'b1;
            enq_bundle = rand_bundle(base + 32'(4 * next_in));
            next_in++;
            tick();
        end
        checks++; if (count !== 3'd4 || enq_ready !== 1'b0) begin
            failures++; $display("FAIL wrap_full got cnt=%0d rdy=%b exp 4/0", count, enq_ready); end
        // Full refuses the enqueue on the first overlapped cycle, so the
        // steady occupancy afterwards is DEPTH-1.
        deq_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c >= 1) begin
                checks++; if (count !== 3'd3) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=3", c, count); end
            end
            checks++; if (deq_bundle.pc !== base + 32'(4 * next_out)) begin
                failures++; $display("FAIL wrap_order%0d got=%h exp=%h", c, deq_bundle.pc, base + 32'(4 * next_out)); end
            next_out++;
            if (c >= 1) begin
                enq_bundle = rand_bundle(base + 32'(4 * next_in));
                next_in++;
            end
            tick();
        end
        idle_inputs();
        deq_ready = 1'b1;
        for (int c = 0; c < 8 && model_q.size() > 0; c++) tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        deq_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            enq_valid  = 1'b1;
            enq_bundle = rand_bundle(32'h8000_3000 + 32'(4 * k));
            tick();
        end
        flush      = 1'b1;
        enq_bundle = rand_bundle(32'hDEAD_0000);
        tick();
        idle_inputs();
        checks++; if (deq_valid !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL flush_empty got v=%b cnt=%0d exp 0/0", deq_valid, count); end
        deq_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost%0d got=%b exp=0", c, deq_valid); end
            tick();
        end
        enq_valid  = 1'b1;
        enq_bundle = rand_bundle(32'h8000_3100);
        deq_ready  = 1'b0;
        tick();
        enq_valid = 1'b0;
        checks++; if (deq_valid !== 1'b1 || deq_bundle.pc !== 32'h8000_3100) begin
            failures++; $display("FAIL flush_after got v=%b pc=%h exp 1/80003100", deq_valid, deq_bundle.pc); end
        deq_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        deq_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            enq_valid  = 1'b1;
            enq_bundle = rand_bundle(32'h8000_4000 + 32'(4 * k));
            tick();
        end
        reset      = 1'b1;
        enq_bundle = rand_bundle(32'h8000_4008);
        deq_ready  = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
            failures++; $display("FAIL reset_mid got cnt=%0d v=%b rdy=%b exp 0/0/1", count, deq_valid, enq_ready); end
        checks++; if (deq_bundle !== '0) begin failures++; $display("FAIL reset_mid_bundle got=%h exp=0", deq_bundle); end
    endtask

`ifdef ISSUE_QUEUE_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        // Four fill edges: stall counted while 1..3 entries held -> 3.
        for (int k = 0; k < 4; k++) begin
            enq_valid  = 1'b1;
            enq_bundle = rand_bundle(32'h8000_5000 + 32'(4 * k));
            tick();
        end
        enq_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        checks++; if (perf_full_cycles !== 64'd10) begin
            failures++; $display("FAIL perf_full got=%0d exp=10", perf_full_cycles); end
        checks++; if (perf_stall_cycles !== 64'd13) begin
            failures++; $display("FAIL perf_stall got=%0d exp=13", perf_stall_cycles); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++; if (perf_full_cycles !== 64'd11 || perf_stall_cycles !== 64'd14) begin
            failures++; $display("FAIL perf_flush got=%0d/%0d exp=11/14", perf_full_cycles, perf_stall_cycles); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            checks++; if (count !== PTR_W'(model_q.size())) begin
                failures++; $display("FAIL rand_count%0d got=%0d exp=%0d", c, count, model_q.size()); end
            checks++; if (deq_valid !== (model_q.size() != 0) || enq_ready !== (model_q.size() != DEPTH)) begin
                failures++; $display("FAIL rand_flags%0d got v=%b r=%b size=%0d", c, deq_valid, enq_ready, model_q.size()); end
            if (model_q.size() != 0) begin
                checks++; if (deq_bundle !== model_q[0]) begin
                    failures++; $display("FAIL rand_head%0d got=%h exp=%h", c, deq_bundle.pc, model_q[0].pc); end
            end
`ifdef ISSUE_QUEUE_PERF_EN
            checks++; if (perf_full_cycles !== m_full || perf_stall_cycles !== m_stall) begin
                failures++; $display("FAIL rand_perf%0d got=%0d/%0d exp=%0d/%0d", c, perf_full_cycles,
                                     perf_stall_cycles, m_full, m_stall); end
`endif
            enq_valid  = ($urandom_range(0, 3) != 0);
            deq_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            reset      = ($urandom_range(0, 80) == 0);
            enq_bundle = rand_bundle($urandom);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill_block();
        test_simul_wrap();
        test_flush();
        test_reset_mid();
`ifdef ISSUE_QUEUE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_issue_queue
